// File: rtl/prbs_lfsr_gen_chk.sv
// Parametrised PRBS generator (maximal-length or de Bruijn) plus a self-synchronising
// serial checker that shares the same feedback function.
module prbs_lfsr_gen_chk #(
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] TAPS      = 3'b011,
    parameter int               ERR_LIMIT = 4,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] SEED,
    input  logic             MODE,
    output logic [WIDTH-1:0] Q,
    output logic             DOUT,
    output logic             WRAP,
    input  logic             DIN,
    input  logic             DIN_VALID,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
);
    localparam int               HC_W     = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] TOP_BIT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [HC_W-1:0]  HC_ZERO  = {HC_W{1'b0}};
    localparam logic [HC_W-1:0]  HC_ONE   = HC_W'(1);
    localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(WIDTH - 1);
    localparam logic [3:0]       MC_LAST  = 4'(ERR_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_CHECK = 1'b1} chk_state_t;

    // In de Bruijn mode the all-zero-above-exit term splices 0...0 into the cycle.
    function automatic logic feedback(input logic [WIDTH-1:0] r, input logic de_bruijn);
        logic upper_zero;
        upper_zero = (r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
        return (^(r & TAPS)) ^ (de_bruijn & upper_zero);
    endfunction

    logic [WIDTH-1:0] q_q, q_d, seed_q, seed_d, step_s;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] r_q, r_d, hunt_r_s;
    logic [HC_W-1:0]  hc_q, hc_d;
    logic [3:0]       mc_q, mc_d;
    chk_state_t       st_q, st_d;
    logic             locked_q, locked_d, err_q, err_d, mode_q, exp_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Generator next state: LOAD beats EN, MODE=0 escapes the all-zero lock-up.
    always_comb begin
        step_s = {feedback(q_q, MODE), q_q[WIDTH-1:1]};
        if (!MODE && (q_q == ALL_ZERO)) begin
            step_s = TOP_BIT;
        end else begin
            step_s = {feedback(q_q, MODE), q_q[WIDTH-1:1]};
        end
        q_d    = q_q;
        seed_d = seed_q;
        wrap_d = 1'b0;
        if (LOAD) begin
            q_d    = SEED;
            seed_d = SEED;
        end else if (EN) begin
            q_d    = step_s;
            wrap_d = (step_s == seed_q);
        end else begin
            q_d = q_q;
        end
    end

    // Checker FSM: a MODE change discards the current bit and restarts the hunt.
    always_comb begin
        st_d     = st_q;
        r_d      = r_q;
        hc_d     = hc_q;
        mc_d     = mc_q;
        err_d    = 1'b0;
        hunt_r_s = {DIN, r_q[WIDTH-1:1]};
        exp_s    = feedback(r_q, MODE);
        if (MODE != mode_q) begin
            st_d = ST_HUNT;
            hc_d = HC_ZERO;
            mc_d = 4'd0;
        end else if (DIN_VALID) begin
            case (st_q)
                ST_HUNT: begin
                    r_d = hunt_r_s;
                    if (hc_q == HC_LAST) begin
                        hc_d = HC_ZERO;
                        if (!MODE && (hunt_r_s == ALL_ZERO)) begin
                            st_d = ST_HUNT;
                        end else begin
                            st_d = ST_CHECK;
                        end
                    end else begin
                        hc_d = hc_q + HC_ONE;
                    end
                end
                ST_CHECK: begin
                    r_d = {exp_s, r_q[WIDTH-1:1]};
                    if (DIN != exp_s) begin
                        err_d = 1'b1;
                        if (mc_q == MC_LAST) begin
                            st_d = ST_HUNT;
                            hc_d = HC_ZERO;
                            mc_d = 4'd0;
                        end else begin
                            mc_d = mc_q + 4'd1;
                        end
                    end else begin
                        mc_d = 4'd0;
                    end
                end
                default: begin
                    st_d = ST_HUNT;
                    hc_d = HC_ZERO;
                    mc_d = 4'd0;
                end
            endcase
        end else begin
            st_d = st_q;
        end
        locked_d = (st_d == ST_CHECK);
        if (CLR_CNT) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (err_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers for generator and checker.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            q_q      <= TOP_BIT;
            seed_q   <= TOP_BIT;
            wrap_q   <= 1'b0;
            r_q      <= ALL_ZERO;
            hc_q     <= HC_ZERO;
            mc_q     <= 4'd0;
            st_q     <= ST_HUNT;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            mode_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            seed_q   <= seed_d;
            wrap_q   <= wrap_d;
            r_q      <= r_d;
            hc_q     <= hc_d;
            mc_q     <= mc_d;
            st_q     <= st_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            mode_q   <= MODE;
        end
    end

    assign Q       = q_q;
    assign DOUT    = q_q[0];
    assign WRAP    = wrap_q;
    assign LOCKED  = locked_q;
    assign ERR     = err_q;
    assign ERR_CNT = cnt_q;

endmodule

// File: tb/tb_prbs_lfsr_gen_chk.sv
// Scoreboard bench for prbs_lfsr_gen_chk at W=3, TAPS=011.
module tb_prbs_lfsr_gen_chk;
    logic        CLK       = 1'b0;
    logic        RESET_L   = 1'b1;
    logic        EN        = 1'b0;
    logic        LOAD      = 1'b0;
    logic        MODE      = 1'b0;
    logic        DIN       = 1'b0;
    logic        DIN_VALID = 1'b0;
    logic        CLR_CNT   = 1'b0;
    logic [2:0]  SEED      = 3'b000;
    logic [2:0]  Q;
    logic        DOUT, WRAP, LOCKED, ERR;
    logic [15:0] ERR_CNT;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [2:0] q; logic wrap; } gen_exp_t;
    typedef struct packed { logic err; logic locked; logic [15:0] cnt; } chk_exp_t;
    gen_exp_t gen_sb[$];
    chk_exp_t chk_sb[$];

    prbs_lfsr_gen_chk dut (
        .CLK(CLK), .RESET_L(RESET_L), .EN(EN), .LOAD(LOAD), .SEED(SEED), .MODE(MODE),
        .Q(Q), .DOUT(DOUT), .WRAP(WRAP), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .CLR_CNT(CLR_CNT), .LOCKED(LOCKED), .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        #1 RESET_L = 1'b0;
        #2;
        total++;
        if ({Q, DOUT, WRAP, ERR, LOCKED, ERR_CNT} !== {3'b100, 4'b0000, 16'd0}) begin
            bad++;
            $display("FAIL reset_async: got q=%b dout=%b wrap=%b err=%b locked=%b cnt=%0d want q=100 others 0",
                     Q, DOUT, WRAP, ERR, LOCKED, ERR_CNT);
        end
        EN = 1'b1;
        @(posedge CLK); #1;
        total++;
        if (Q !== 3'b100) begin
            bad++;
            $display("FAIL reset_hold: got q=%b want 100", Q);
        end
        EN = 1'b0;
        RESET_L = 1'b1;
    endtask

    task automatic test_gen_debruijn();
        logic [2:0] tbl [9];
        gen_exp_t e;
        tbl = '{3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000, 3'b100, 3'b010};
        MODE = 1'b1; EN = 1'b0; DIN_VALID = 1'b0;
        RESET_L = 1'b0; #2 RESET_L = 1'b1;
        for (int i = 0; i < 9; i++) begin
            EN = 1'b1;
            gen_sb.push_back({tbl[i], (i == 7)});
            @(posedge CLK); #1;
            e = gen_sb.pop_front();
            total++;
            if ({Q, DOUT, WRAP} !== {e.q, e.q[0], e.wrap}) begin
                bad++;
                $display("FAIL debruijn_step%0d: got q=%b dout=%b wrap=%b want q=%b dout=%b wrap=%b",
                         i + 1, Q, DOUT, WRAP, e.q, e.q[0], e.wrap);
            end
        end
        EN = 1'b0;
    endtask

    task automatic test_gen_maximal();
        logic [2:0] tbl [9];
        logic       ld  [9];
        gen_exp_t e;
        tbl = '{3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b100, 3'b000, 3'b100};
        ld  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        MODE = 1'b0; EN = 1'b0;
        RESET_L = 1'b0; #2 RESET_L = 1'b1;
        for (int i = 0; i < 9; i++) begin
            LOAD = ld[i]; EN = ~ld[i]; SEED = 3'b000;
            gen_sb.push_back({tbl[i], (i == 6)});
            @(posedge CLK); #1;
            e = gen_sb.pop_front();
            total++;
            if ({Q, DOUT, WRAP} !== {e.q, e.q[0], e.wrap}) begin
                bad++;
                $display("FAIL maximal_step%0d: got q=%b dout=%b wrap=%b want q=%b dout=%b wrap=%b",
                         i + 1, Q, DOUT, WRAP, e.q, e.q[0], e.wrap);
            end
        end
        LOAD = 1'b0; EN = 1'b0;
    endtask

    task automatic test_load_priority();
        logic [2:0] tbl [9];
        gen_exp_t e;
        tbl = '{3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b100, 3'b010, 3'b101, 3'b101};
        MODE = 1'b0;
        for (int i = 0; i < 9; i++) begin
            LOAD = (i == 0); EN = (i < 8); SEED = 3'b101;
            gen_sb.push_back({tbl[i], (i == 7)});
            @(posedge CLK); #1;
            e = gen_sb.pop_front();
            total++;
            if ({Q, WRAP} !== {e.q, e.wrap}) begin
                bad++;
                $display("FAIL load_step%0d: got q=%b wrap=%b want q=%b wrap=%b", i, Q, WRAP, e.q, e.wrap);
            end
        end
        LOAD = 1'b0; EN = 1'b0;
    endtask

    task automatic test_loopback();
        chk_exp_t c;
        MODE = 1'b1; EN = 1'b0; DIN_VALID = 1'b0;
        RESET_L = 1'b0; #2 RESET_L = 1'b1;
        for (int i = 0; i < 103; i++) begin
            EN = (i > 0); DIN_VALID = (i > 0);
            DIN = DOUT ^ (i == 101);
            if (i == 0)
                chk_sb.push_back({1'b0, 1'b0, 16'd0});
            else if (i <= 100)
                chk_sb.push_back({1'b0, (i >= 3), 16'd0});
            else
                chk_sb.push_back({(i == 101), 1'b1, 16'd1});
            @(posedge CLK); #1;
            c = chk_sb.pop_front();
            total++;
            if ({ERR, LOCKED, ERR_CNT} !== c) begin
                bad++;
                $display("FAIL loopback_bit%0d: got err=%b locked=%b cnt=%0d want err=%b locked=%b cnt=%0d",
                         i, ERR, LOCKED, ERR_CNT, c.err, c.locked, c.cnt);
            end
        end
    endtask

    task automatic test_err_burst();
        logic     inv [9];
        logic     clr [9];
        chk_exp_t xp  [9];
        chk_exp_t c;
        inv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        clr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        xp  = '{{1'b0, 1'b1, 16'd0}, {1'b1, 1'b1, 16'd1}, {1'b1, 1'b1, 16'd2},
                {1'b1, 1'b1, 16'd3}, {1'b1, 1'b0, 16'd4}, {1'b0, 1'b0, 16'd4},
                {1'b0, 1'b0, 16'd4}, {1'b0, 1'b1, 16'd4}, {1'b0, 1'b1, 16'd4}};
        for (int i = 0; i < 9; i++) begin
            EN = 1'b1; DIN_VALID = 1'b1; CLR_CNT = clr[i];
            DIN = DOUT ^ inv[i];
            chk_sb.push_back(xp[i]);
            @(posedge CLK); #1;
            c = chk_sb.pop_front();
            total++;
            if ({ERR, LOCKED, ERR_CNT} !== c) begin
                bad++;
                $display("FAIL burst_bit%0d: got err=%b locked=%b cnt=%0d want err=%b locked=%b cnt=%0d",
                         i, ERR, LOCKED, ERR_CNT, c.err, c.locked, c.cnt);
            end
        end
        CLR_CNT = 1'b0;
    endtask

    task automatic test_mode_clr();
        logic     md  [7];
        logic     act [7];
        logic     inv [7];
        chk_exp_t xp  [7];
        chk_exp_t c;
        md  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        act = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        inv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        xp  = '{{1'b0, 1'b0, 16'd4}, {1'b0, 1'b0, 16'd4}, {1'b0, 1'b0, 16'd4},
                {1'b0, 1'b0, 16'd4}, {1'b0, 1'b1, 16'd4}, {1'b1, 1'b1, 16'd0},
                {1'b0, 1'b1, 16'd0}};
        for (int i = 0; i < 7; i++) begin
            MODE = md[i]; EN = act[i]; DIN_VALID = act[i]; CLR_CNT = inv[i];
            DIN = DOUT ^ inv[i];
            chk_sb.push_back(xp[i]);
            @(posedge CLK); #1;
            c = chk_sb.pop_front();
            total++;
            if ({ERR, LOCKED, ERR_CNT} !== c) begin
                bad++;
                $display("FAIL mode_clr_step%0d: got err=%b locked=%b cnt=%0d want err=%b locked=%b cnt=%0d",
                         i, ERR, LOCKED, ERR_CNT, c.err, c.locked, c.cnt);
            end
        end
        CLR_CNT = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [2:0] tbl [3];
        gen_exp_t e;
        tbl = '{3'b010, 3'b101, 3'b110};
        EN = 1'b1; DIN_VALID = 1'b1; DIN = ~DOUT;
        @(posedge CLK); #1;
        total++;
        if ({ERR, LOCKED, ERR_CNT} !== {1'b1, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL prereset_err: got err=%b locked=%b cnt=%0d want 1 1 1", ERR, LOCKED, ERR_CNT);
        end
        DIN = DOUT;
        RESET_L = 1'b0;
        #2;
        total++;
        if ({Q, LOCKED, ERR_CNT, ERR, WRAP} !== {3'b100, 1'b0, 16'd0, 2'b00}) begin
            bad++;
            $display("FAIL midstream_reset: got q=%b locked=%b cnt=%0d err=%b wrap=%b want q=100 0 0 0 0",
                     Q, LOCKED, ERR_CNT, ERR, WRAP);
        end
        RESET_L = 1'b1;
        DIN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            EN = 1'b1;
            gen_sb.push_back({tbl[i], 1'b0});
            @(posedge CLK); #1;
            e = gen_sb.pop_front();
            total++;
            if ({Q, WRAP} !== {e.q, e.wrap}) begin
                bad++;
                $display("FAIL restart_step%0d: got q=%b wrap=%b want q=%b wrap=%b", i + 1, Q, WRAP, e.q, e.wrap);
            end
        end
        EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gen_debruijn();
        test_gen_maximal();
        test_load_priority();
        test_loopback();
        test_err_burst();
        test_mode_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
